// File: rtl/register_serializer.sv
// register_serializer
//   Parallel-in, serial-out reader for a size-bit register word. An accepted load captures d.
//   The word is then shifted out one bit per clock, qualified by sout_valid. A one-cycle done
//   pulse follows the last bit. All outputs come straight from flops.
//
// Parameters
//   size       width of the parallel word (1..64)
//   msb_first  0: d[0] goes out first; 1: d[size-1] goes out first
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high; overrides load and any word in flight
//   d           parallel word, sampled only on an accepted load
//   load        load request, accepted only while idle (busy==0)
//   busy        high while shifting and during the done cycle
//   sout        current serial bit, meaningful while sout_valid==1
//   sout_valid  high for exactly size consecutive cycles per word
//   done        one-cycle pulse in the cycle after the last valid bit
module register_serializer #(
    parameter int unsigned size      = 8,
    parameter bit          msb_first = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [size-1:0] d,
    input  logic            load,
    output logic            busy,
    output logic            sout,
    output logic            sout_valid,
    output logic            done
);

    localparam int unsigned CntW = (size > 1) ? $clog2(size) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(size - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [size-1:0]   shift_q, shift_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              sout_q, sout_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    // Word after one shift step; the outgoing end is always the bit presented on sout.
    logic [size-1:0]   shift_next;
    assign shift_next = msb_first ? (shift_q << 1) : (shift_q >> 1);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        sout_d  = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    state_d = StShift;
                    shift_d = d;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    sout_d  = msb_first ? d[size-1] : d[0];
                end
            end
            StShift: begin
                busy_d = 1'b1;
                if (cnt_q == CntLast) begin
                    // Last bit was on sout this cycle; close out the word.
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    shift_d = shift_next;
                    cnt_d   = cnt_q + CntW'(1);
                    valid_d = 1'b1;
                    sout_d  = msb_first ? shift_next[size-1] : shift_next[0];
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            sout_q  <= sout_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign sout       = sout_q;
    assign sout_valid = valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_register_serializer.sv
// Directed bench for register_serializer: an LSB-first and an MSB-first 8-bit instance plus a
// 1-bit instance, sharing clock and reset. Outputs are checked 1 time unit after each edge as
// the 4-bit tuple {busy, sout_valid, sout, done}.
module tb_register_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] d_a, d_b;
    logic [0:0] d_c;
    logic       load_a, load_b, load_c;
    logic       busy_a, sout_a, valid_a, done_a;
    logic       busy_b, sout_b, valid_b, done_b;
    logic       busy_c, sout_c, valid_c, done_c;

    int errors = 0;
    int checks = 0;

    register_serializer #(.size(8), .msb_first(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .d(d_a), .load(load_a),
        .busy(busy_a), .sout(sout_a), .sout_valid(valid_a), .done(done_a)
    );

    register_serializer #(.size(8), .msb_first(1'b1)) u_msb (
        .clk(clk), .rst(rst), .d(d_b), .load(load_b),
        .busy(busy_b), .sout(sout_b), .sout_valid(valid_b), .done(done_b)
    );

    register_serializer #(.size(1), .msb_first(1'b0)) u_one (
        .clk(clk), .rst(rst), .d(d_c), .load(load_c),
        .busy(busy_c), .sout(sout_c), .sout_valid(valid_c), .done(done_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        rst = 1'b1;
        load_a = 1'b1; load_b = 1'b1; load_c = 1'b1;
        d_a = 8'hFF; d_b = 8'hFF; d_c = 1'b1;
        step();
        step();
        exp = 4'b0000;
        checks++;
        if ({busy_a, valid_a, sout_a, done_a} !== exp) begin
            errors++;
            $display("FAIL reset_lsb: got %b want %b", {busy_a, valid_a, sout_a, done_a}, exp);
        end
        checks++;
        if ({busy_b, valid_b, sout_b, done_b} !== exp) begin
            errors++;
            $display("FAIL reset_msb: got %b want %b", {busy_b, valid_b, sout_b, done_b}, exp);
        end
        checks++;
        if ({busy_c, valid_c, sout_c, done_c} !== exp) begin
            errors++;
            $display("FAIL reset_one: got %b want %b", {busy_c, valid_c, sout_c, done_c}, exp);
        end
        // Release reset with load low: nothing may have been captured during reset.
        rst = 1'b0;
        load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
        step();
        checks++;
        if ({busy_a, valid_a, sout_a, done_a} !== exp) begin
            errors++;
            $display("FAIL reset_idle_lsb: got %b want %b", {busy_a, valid_a, sout_a, done_a}, exp);
        end
        step();
    endtask

    task automatic test_lsb_first();
        logic [7:0] bits;
        logic [3:0] exp;
        bits = 8'b0000_0010 | 8'b0001_0000;  // 8'h12 streamed LSB first
        d_a = 8'h12;
        load_a = 1'b1;
        step();
        load_a = 1'b0;
        d_a = 8'h00;
        for (int k = 0; k < 8; k++) begin
            exp = {1'b1, 1'b1, bits[k], 1'b0};
            checks++;
            if ({busy_a, valid_a, sout_a, done_a} !== exp) begin
                errors++;
                $display("FAIL lsb_bit%0d: got %b want %b", k,
                         {busy_a, valid_a, sout_a, done_a}, exp);
            end
            step();
        end
        exp = 4'b1001;
        checks++;
        if ({busy_a, valid_a, sout_a, done_a} !== exp) begin
            errors++;
            $display("FAIL lsb_done: got %b want %b", {busy_a, valid_a, sout_a, done_a}, exp);
        end
        step();
        exp = 4'b0000;
        checks++;
        if ({busy_a, valid_a, sout_a, done_a} !== exp) begin
            errors++;
            $display("FAIL lsb_idle: got %b want %b", {busy_a, valid_a, sout_a, done_a}, exp);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] seq;
        logic [3:0] exp;
        seq = 8'b0001_0010;  // expected order 0,0,0,1,0,0,1,0 read from seq[7] down
        d_b = 8'h12;
        load_b = 1'b1;
        step();
        load_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp = {1'b1, 1'b1, seq[7-k], 1'b0};
            checks++;
            if ({busy_b, valid_b, sout_b, done_b} !== exp) begin
                errors++;
                $display("FAIL msb_bit%0d: got %b want %b", k,
                         {busy_b, valid_b, sout_b, done_b}, exp);
            end
            step();
        end
        exp = 4'b1001;
        checks++;
        if ({busy_b, valid_b, sout_b, done_b} !== exp) begin
            errors++;
            $display("FAIL msb_done: got %b want %b", {busy_b, valid_b, sout_b, done_b}, exp);
        end
        step();
        exp = 4'b0000;
        checks++;
        if ({busy_b, valid_b, sout_b, done_b} !== exp) begin
            errors++;
            $display("FAIL msb_idle: got %b want %b", {busy_b, valid_b, sout_b, done_b}, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w0, w1;
        logic [3:0] exp;
        w0 = 8'hA5;
        w1 = 8'h0F;
        d_a = w0;
        load_a = 1'b1;
        step();                   // E0: A5 accepted
        d_a = w1;                 // load stays high through SHIFT and DONE
        for (int k = 0; k < 8; k++) begin
            exp = {1'b1, 1'b1, w0[k], 1'b0};
            checks++;
            if ({busy_a, valid_a, sout_a, done_a} !== exp) begin
                errors++;
                $display("FAIL b2b_w0_bit%0d: got %b want %b", k,
                         {busy_a, valid_a, sout_a, done_a}, exp);
            end
            step();
        end
        exp = 4'b1001;            // after E8
        checks++;
        if ({busy_a, valid_a, sout_a, done_a} !== exp) begin
            errors++;
            $display("FAIL b2b_done0: got %b want %b", {busy_a, valid_a, sout_a, done_a}, exp);
        end
        step();
        exp = 4'b0000;            // after E9: load ignored in DONE
        checks++;
        if ({busy_a, valid_a, sout_a, done_a} !== exp) begin
            errors++;
            $display("FAIL b2b_gap: got %b want %b", {busy_a, valid_a, sout_a, done_a}, exp);
        end
        step();                   // E10: 0F accepted
        load_a = 1'b0;
        d_a = 8'h00;
        for (int k = 0; k < 8; k++) begin
            exp = {1'b1, 1'b1, w1[k], 1'b0};
            checks++;
            if ({busy_a, valid_a, sout_a, done_a} !== exp) begin
                errors++;
                $display("FAIL b2b_w1_bit%0d: got %b want %b", k,
                         {busy_a, valid_a, sout_a, done_a}, exp);
            end
            step();
        end
        exp = 4'b1001;
        checks++;
        if ({busy_a, valid_a, sout_a, done_a} !== exp) begin
            errors++;
            $display("FAIL b2b_done1: got %b want %b", {busy_a, valid_a, sout_a, done_a}, exp);
        end
        step();
    endtask

    task automatic test_reset_mid();
        logic [7:0] w;
        logic [3:0] exp;
        d_a = 8'hFF;
        load_a = 1'b1;
        step();                   // E0: bit 0 on sout
        load_a = 1'b0;
        step();
        step();
        step();                   // E3: 4th bit on sout
        exp = 4'b1110;
        checks++;
        if ({busy_a, valid_a, sout_a, done_a} !== exp) begin
            errors++;
            $display("FAIL mid_pre: got %b want %b", {busy_a, valid_a, sout_a, done_a}, exp);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp = 4'b0000;
        checks++;
        if ({busy_a, valid_a, sout_a, done_a} !== exp) begin
            errors++;
            $display("FAIL mid_abort: got %b want %b", {busy_a, valid_a, sout_a, done_a}, exp);
        end
        // Fresh load at the first edge with rst low; done must stay low throughout.
        w = 8'h01;
        d_a = w;
        load_a = 1'b1;
        step();
        load_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp = {1'b1, 1'b1, w[k], 1'b0};
            checks++;
            if ({busy_a, valid_a, sout_a, done_a} !== exp) begin
                errors++;
                $display("FAIL mid_reload_bit%0d: got %b want %b", k,
                         {busy_a, valid_a, sout_a, done_a}, exp);
            end
            step();
        end
        exp = 4'b1001;
        checks++;
        if ({busy_a, valid_a, sout_a, done_a} !== exp) begin
            errors++;
            $display("FAIL mid_reload_done: got %b want %b",
                     {busy_a, valid_a, sout_a, done_a}, exp);
        end
        step();
    endtask

    task automatic test_size_one();
        logic [3:0] exp;
        d_c = 1'b1;
        load_c = 1'b1;
        step();
        load_c = 1'b0;
        d_c = 1'b0;
        exp = 4'b1110;
        checks++;
        if ({busy_c, valid_c, sout_c, done_c} !== exp) begin
            errors++;
            $display("FAIL one_bit: got %b want %b", {busy_c, valid_c, sout_c, done_c}, exp);
        end
        step();
        exp = 4'b1001;
        checks++;
        if ({busy_c, valid_c, sout_c, done_c} !== exp) begin
            errors++;
            $display("FAIL one_done: got %b want %b", {busy_c, valid_c, sout_c, done_c}, exp);
        end
        step();
        exp = 4'b0000;
        checks++;
        if ({busy_c, valid_c, sout_c, done_c} !== exp) begin
            errors++;
            $display("FAIL one_idle: got %b want %b", {busy_c, valid_c, sout_c, done_c}, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
        d_a = '0; d_b = '0; d_c = '0;
        #1;
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_back_to_back();
        test_reset_mid();
        test_size_one();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
